// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared definitions for the fetch stall controller: FSM state encoding,
// the HALT opcode and the default bubble encoding.
package fetch_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [4:0]  HALT_OPCODE = 5'b00000;
  localparam logic [15:0] DEFAULT_NOP = 16'h0800;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter register. A redirect load takes precedence over the
// hold enable; otherwise the PC advances by 2 each cycle, wrapping modulo 2^16.
module fetch_pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        load_redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pc
);

  // PC update: redirect target, hold, or sequential advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else if (load_redirect)
      pc <= redirect_pc;
    else if (!hold)
      pc <= pc + 16'd2;
  end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage stall controller: owns the PC and the IF/ID latch, applies
// redirects, hazard stalls/bubbles and HALT freezing with fixed priority.
// Optional stall-cycle counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] NOP_INSTR    = DEFAULT_NOP,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ImemInstr,
  input  logic        ImemValid,
  input  logic        HazNop,
  input  logic        HazPcStall,
  input  logic        Redirect,
  input  logic [15:0] RedirectPc,
  output logic [15:0] Pc,
  output logic [15:0] IfIdInstr,
  output logic [15:0] IfIdPcPlus2,
  output logic        IfIdValid,
  output logic        Halted,
  output logic [15:0] StallCount
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  fetch_state_t state, next_state;
  logic [2:0]   flush_cnt, next_cnt;
  logic         pc_hold;
  logic         pc_redirect;
  logic         ifid_load;
  logic         ifid_bubble;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold         (pc_hold),
    .load_redirect(pc_redirect),
    .redirect_pc  (RedirectPc),
    .pc           (Pc)
  );

  // State and flush counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= next_state;
      flush_cnt <= next_cnt;
    end
  end

  // Next-state and fetch control; a redirect wins in every state
  always_comb begin
    next_state  = state;
    next_cnt    = flush_cnt;
    pc_hold     = 1'b1;
    pc_redirect = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (Redirect) begin
      pc_redirect = 1'b1;
      ifid_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        next_state = ST_FLUSH;
        next_cnt   = FLUSH_INIT;
      end else begin
        next_state = ST_RUN;
        next_cnt   = 3'd0;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (HazPcStall) begin
            ifid_bubble = HazNop;
          end else if (HazNop) begin
            ifid_bubble = 1'b1;
            pc_hold     = 1'b0;
          end else if (!ImemValid) begin
            ifid_bubble = 1'b1;
          end else begin
            ifid_load = 1'b1;
            pc_hold   = 1'b0;
            if (ImemInstr[15:11] == HALT_OPCODE)
              next_state = ST_HALT;
          end
        end
        ST_FLUSH: begin
          ifid_bubble = 1'b1;
          next_cnt    = flush_cnt - 3'd1;
          if (flush_cnt <= 3'd1) begin
            next_cnt   = 3'd0;
            next_state = ST_RUN;
          end
        end
        ST_HALT: begin
          ifid_bubble = 1'b1;
        end
        default: begin
          next_state = ST_RUN;
          next_cnt   = 3'd0;
        end
      endcase
    end
  end

  // IF/ID latch: load a fetched instruction, inject a bubble, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IfIdInstr   <= NOP_INSTR;
      IfIdPcPlus2 <= 16'h0000;
      IfIdValid   <= 1'b0;
    end else if (ifid_load) begin
      IfIdInstr   <= ImemInstr;
      IfIdPcPlus2 <= Pc + 16'd2;
      IfIdValid   <= 1'b1;
    end else if (ifid_bubble) begin
      IfIdInstr   <= NOP_INSTR;
      IfIdValid   <= 1'b0;
    end
  end

  assign Halted = (state == ST_HALT);

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic        stall_event;

  assign stall_event = (state == ST_RUN) && HazPcStall && !Redirect;

  // Saturating count of RUN-state PC stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= 16'h0000;
    else if (stall_event && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed self-checking bench for fetch_stall_ctrl (FLUSH_CYCLES = 2).
// Instruction memory is a fixed function of the address; 0x0010 holds HALT.
module tb_fetch_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] ImemInstr;
  logic        ImemValid;
  logic        HazNop;
  logic        HazPcStall;
  logic        Redirect;
  logic [15:0] RedirectPc;
  logic [15:0] Pc;
  logic [15:0] IfIdInstr;
  logic [15:0] IfIdPcPlus2;
  logic        IfIdValid;
  logic        Halted;
  logic [15:0] StallCount;

  int errors = 0;
  int checks = 0;

  fetch_stall_ctrl #(
    .RESET_PC    (16'h0000),
    .NOP_INSTR   (16'h0800),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ImemInstr  (ImemInstr),
    .ImemValid  (ImemValid),
    .HazNop     (HazNop),
    .HazPcStall (HazPcStall),
    .Redirect   (Redirect),
    .RedirectPc (RedirectPc),
    .Pc         (Pc),
    .IfIdInstr  (IfIdInstr),
    .IfIdPcPlus2(IfIdPcPlus2),
    .IfIdValid  (IfIdValid),
    .Halted     (Halted),
    .StallCount (StallCount)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: 0x4000 + (addr/2)*0x0101, HALT at 0x0010
  function automatic logic [15:0] instrAt(input logic [15:0] addr);
    logic [15:0] half;
    half = addr >> 1;
    if (addr == 16'h0010) return 16'h0000;
    return 16'h4000 + half * 16'h0101;
  endfunction

  assign ImemInstr = instrAt(Pc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic redir, input logic [15:0] rpc,
                               input logic stall, input logic nop,
                               input logic valid);
    Redirect   = redir;
    RedirectPc = rpc;
    HazPcStall = stall;
    HazNop     = nop;
    ImemValid  = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIfId(input string tag, input logic [15:0] pc_exp,
                           input logic [15:0] instr_exp,
                           input logic [15:0] pp2_exp, input logic valid_exp);
    checkOutput({tag, "_pc"}, Pc, pc_exp);
    checkOutput({tag, "_instr"}, IfIdInstr, instr_exp);
    checkOutput({tag, "_pp2"}, IfIdPcPlus2, pp2_exp);
    checkOutput({tag, "_valid"}, {15'd0, IfIdValid}, {15'd0, valid_exp});
  endtask

  function automatic logic [15:0] expCount(input logic [15:0] n);
`ifdef FETCH_STALL_CNT_EN
    return n;
`else
    return (n == 16'hFFFF) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkIfId("reset", 16'h0000, 16'h0800, 16'h0000, 1'b0);
    checkOutput("reset_halted", {15'd0, Halted}, 16'h0000);
    checkOutput("reset_cnt", StallCount, 16'h0000);
    rst_n = 1'b1;

    // Sequential fetch from reset address
    tick();
    checkIfId("fetch0", 16'h0002, 16'h4000, 16'h0002, 1'b1);
    tick();
    checkIfId("fetch2", 16'h0004, 16'h4101, 16'h0004, 1'b1);
    tick();
    checkIfId("fetch4", 16'h0006, 16'h4202, 16'h0006, 1'b1);

    // Stall plus bubble for two cycles at Pc=6
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    tick();
    checkIfId("stallnop1", 16'h0006, 16'h0800, 16'h0006, 1'b0);
    tick();
    checkIfId("stallnop2", 16'h0006, 16'h0800, 16'h0006, 1'b0);
    checkOutput("cnt_after2", StallCount, expCount(16'd2));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    checkIfId("resume6", 16'h0008, 16'h4303, 16'h0008, 1'b1);

    // Pure stall holds PC and IF/ID
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();
    checkIfId("stall8", 16'h0008, 16'h4303, 16'h0008, 1'b1);
    checkOutput("cnt_after3", StallCount, expCount(16'd3));

    // HazNop alone: bubble while PC advances
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
    checkIfId("naked_nop", 16'h000A, 16'h0800, 16'h0008, 1'b0);

    // Invalid memory: PC holds, bubble
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    checkIfId("imem_invalid", 16'h000A, 16'h0800, 16'h0008, 1'b0);

    // Redirect with simultaneous stall: redirect wins, two bubbles
    applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0, 1'b1);
    tick();
    checkIfId("redir1", 16'h0040, 16'h0800, 16'h0008, 1'b0);
    checkOutput("cnt_redir", StallCount, expCount(16'd3));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    tick();
    checkIfId("flush", 16'h0040, 16'h0800, 16'h0008, 1'b0);
    checkOutput("cnt_flush", StallCount, expCount(16'd3));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    checkIfId("redir_target", 16'h0042, 16'h6020, 16'h0042, 1'b1);

    // Fetch HALT at 0x0010
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkIfId("halt_fetch", 16'h0012, 16'h0000, 16'h0012, 1'b1);
    checkOutput("halted_set", {15'd0, Halted}, 16'h0001);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    tick();
    checkIfId("halt_hold1", 16'h0012, 16'h0800, 16'h0012, 1'b0);
    tick();
    checkIfId("halt_hold2", 16'h0012, 16'h0800, 16'h0012, 1'b0);
    checkOutput("halt_hold_halted", {15'd0, Halted}, 16'h0001);
    checkOutput("cnt_halt", StallCount, expCount(16'd3));

    // Redirect out of HALT
    applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("unhalt_pc", Pc, 16'h0020);
    checkOutput("unhalt_halted", {15'd0, Halted}, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkIfId("resume20", 16'h0022, 16'h5010, 16'h0022, 1'b1);

    // HALT fetch coinciding with a PC stall: stall wins
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();
    checkIfId("halt_stalled", 16'h0010, 16'h0800, 16'h0022, 1'b0);
    checkOutput("halt_stalled_halted", {15'd0, Halted}, 16'h0000);
    checkOutput("cnt_halt_stall", StallCount, expCount(16'd4));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("halt_late_halted", {15'd0, Halted}, 16'h0001);

    // PC wrap from 0xFFFE
    applyStimulus(1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("wrap_halted", {15'd0, Halted}, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkIfId("wrap", 16'h0000, 16'hBEFF, 16'h0000, 1'b1);

    // Asynchronous reset in the middle of a flush
    applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkIfId("async_reset", 16'h0000, 16'h0800, 16'h0000, 1'b0);
    checkOutput("async_reset_halted", {15'd0, Halted}, 16'h0000);
    checkOutput("async_reset_cnt", StallCount, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    checkIfId("post_reset", 16'h0002, 16'h4000, 16'h0002, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stall_ctrl.md
Name: fetch_stall_ctrl

Overview:
Fetch-stage responder to the hazard detection unit's stall and NOP requests.
- Owns the PC register and the IF/ID pipeline latch.
- Applies PC holds, bubble injection and branch/jump redirects with a fixed priority.
- Tracks HALT so fetch freezes after a halt instruction.
- Sits between instruction memory and decode. Its outputs feed the hazard detector's instruction input and the decode stage.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, encoding injected into IF/ID as a bubble.
- FLUSH_CYCLES, 1, bubble cycles after a redirect; legal range 1..7.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ImemInstr  input  16  instruction read at PC.
- ImemValid  input  1  ImemInstr is valid this cycle.
- HazNop  input  1  hazard unit requests a bubble into IF/ID.
- HazPcStall  input  1  hazard unit requests a PC hold.
- Redirect  input  1  taken branch/jump resolved downstream.
- RedirectPc  input  16  target address for Redirect.
- Pc  output  16  current fetch address, registered.
- IfIdInstr  output  16  instruction presented to decode.
- IfIdPcPlus2  output  16  PC+2 of the instruction in IF/ID.
- IfIdValid  output  1  IF/ID holds a real instruction (not a bubble).
- Halted  output  1  fetch frozen by HALT.
- StallCount  output  16  stall-cycle counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - Pc = RESET_PC.
  - IfIdInstr = NOP_INSTR, IfIdValid = 0, IfIdPcPlus2 = 0.
  - Halted = 0, state = RUN, flush counter = 0, StallCount = 0.
- States: RUN, FLUSH, HALT. Encoding is 2 bits.
- Per-cycle priority in RUN, highest first:
  1. Redirect: Pc <= RedirectPc; IF/ID <= bubble. If FLUSH_CYCLES > 1, go to FLUSH with counter = FLUSH_CYCLES-1; otherwise stay in RUN.
  2. HazPcStall: Pc holds. If HazNop is also set, IF/ID <= bubble; otherwise IF/ID holds all fields.
  3. HazNop alone: IF/ID <= bubble; Pc advances normally. This case is legal but unusual.
  4. !ImemValid: Pc holds; IF/ID <= bubble.
  5. Normal: IfIdInstr <= ImemInstr, IfIdPcPlus2 <= Pc+2, IfIdValid <= 1, Pc <= Pc+2.
- PC arithmetic: 16-bit, wraps modulo 2^16 (16'hFFFE+2 = 16'h0000). No error flag.
- Bubble definition: IfIdInstr = NOP_INSTR, IfIdValid = 0. IfIdPcPlus2 holds its previous value.
- HALT detect: when a normal fetch latches ImemInstr[15:11] == 5'b00000:
  - IF/ID takes the halt instruction with valid = 1.
  - Next state is HALT; Pc holds the halt's address +2.
- HALT state:
  - Halted = 1; Pc holds; IF/ID <= bubble every cycle.
  - Hazard inputs are ignored.
  - Redirect in HALT (an older branch squashing the halt): Pc <= RedirectPc, Halted <= 0, next state RUN or FLUSH per rule 1.
- FLUSH state:
  - Pc holds; IF/ID <= bubble; counter decrements.
  - Exits to RUN when the counter reaches 0.
  - Redirect in FLUSH restarts rule 1 with the new target.
  - Hazard inputs are ignored.
- Simultaneous events:
  - Redirect with HazPcStall: Redirect wins, so the stall is dropped.
  - Halt fetch in the same cycle as HazPcStall: the stall wins; the halt is not latched.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The first fetch is from RESET_PC on the first clock edge after deassertion.
- Latency: a redirect target appears on Pc 1 cycle after Redirect. Its instruction reaches IF/ID FLUSH_CYCLES+1 cycles after Redirect.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined: StallCount increments by 1 on every RUN-state cycle where HazPcStall = 1 and Redirect = 0. It saturates at 16'hFFFF and clears only on reset.
- Undefined: StallCount is tied to 16'h0000 and no counter flops exist.

Decomposition:
- Shared package holds:
  - the state encoding (RUN=2'd0, FLUSH=2'd1, HALT=2'd2);
  - the HALT opcode 5'b00000;
  - the default NOP encoding 16'h0800.
- One sub-module, fetch_pc_reg: a 16-bit PC register with async active-low reset to RESET_PC, hold enable, and next-PC select (Pc+2 or RedirectPc). The FSM and IF/ID latch stay in the top module.

Test Plan:
- Reset release, ImemValid=1, instrs 16'h4000, 16'h4101 -> Pc 0,2,4. IF/ID shows 16'h4000 then 16'h4101 with IfIdValid=1; IfIdPcPlus2 2 then 4.
- HazPcStall=1 and HazNop=1 for 2 cycles at Pc=6 -> Pc stays 6; IF/ID = 16'h0800 with valid=0 for 2 cycles; then fetch resumes at 6. StallCount=2 when the feature is enabled.
- HazPcStall=1, HazNop=0 at Pc=8 -> Pc and IF/ID unchanged for the stall cycle.
- Redirect=1, RedirectPc=16'h0040 together with HazPcStall=1, FLUSH_CYCLES=2 -> Pc=16'h0040 next cycle; 2 bubbles; instr at 0x40 in IF/ID at cycle 3.
- Fetch 16'h0000 at Pc=16'h0010 -> IF/ID valid halt, then Halted=1 and Pc=16'h0012 held. A later Redirect to 16'h0020 -> Halted=0, fetch resumes at 0x20.
- Pc=16'hFFFE normal fetch -> Pc wraps to 16'h0000. rst_n pulsed low mid-FLUSH -> outputs return to reset values without a clock edge.
